// File: rtl/light_fade_driver_pkg.sv
// Shared types and helpers for the lamp fade driver: ramp FSM states and width math.
package light_fade_driver_pkg;

  typedef enum logic [1:0] {
    StIdleOff  = 2'd0,
    StRampUp   = 2'd1,
    StIdleOn   = 2'd2,
    StRampDown = 2'd3
  } state_e;

  function automatic int unsigned duty_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // Bits needed to hold values 0..value-1 (at least one bit).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/light_fade_driver_if.sv
// Level-in / lamp-out bundle between the toggle-light stage and the fade driver.
interface light_fade_driver_if #(
  parameter int unsigned PWM_WIDTH = 8
) ();
  logic                 toglite_state;
  logic                 light_pwm;
  logic [PWM_WIDTH-1:0] duty_level;
  logic                 fading;
  logic                 lockout;

  modport master (
    output toglite_state,
    input  light_pwm, duty_level, fading, lockout
  );

  modport slave (
    input  toglite_state,
    output light_pwm, duty_level, fading, lockout
  );
endinterface

// File: rtl/light_fade_driver_pwm_generator.sv
// Free-running PWM with a per-period shadow duty so mid-period duty changes never glitch.
module light_fade_driver_pwm_generator
  import light_fade_driver_pkg::*;
#(
  parameter int unsigned PWM_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic [PWM_WIDTH-1:0] duty,
  output logic                 light_pwm
);

  localparam logic [PWM_WIDTH-1:0] CntLast = PWM_WIDTH'(duty_max(PWM_WIDTH) - 1);

  logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
  logic [PWM_WIDTH-1:0] shadow_q, shadow_d;
  logic                 pwm_q, pwm_d;

  // Compare against the value latched for this period, including the load cycle itself.
  always_comb begin
    cnt_d    = (cnt_q == CntLast) ? '0 : cnt_q + PWM_WIDTH'(1);
    shadow_d = (cnt_q == '0) ? duty : shadow_q;
    pwm_d    = (cnt_q < shadow_d);
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign light_pwm = pwm_q;

endmodule

// File: rtl/light_fade_driver.sv
// Turns on/off changes of toglite_state into linear PWM duty fades, with a hold-off
// after each accepted change so bursts of misdetections cannot flicker the lamp.
module light_fade_driver
  import light_fade_driver_pkg::*;
#(
  parameter int unsigned PWM_WIDTH        = 8,
  parameter int unsigned FADE_STEP_CYCLES = 1024,
  parameter int unsigned MIN_HOLD_CYCLES  = 50000
) (
  input  logic                clock,
  input  logic                nreset,
  light_fade_driver_if.slave  bus
);

  localparam int unsigned HoldW = clogb2(MIN_HOLD_CYCLES + 1);
  localparam int unsigned StepW = clogb2(FADE_STEP_CYCLES);

  localparam logic [HoldW-1:0]     HoldLoad = HoldW'(MIN_HOLD_CYCLES);
  localparam logic [StepW-1:0]     StepLast = StepW'(FADE_STEP_CYCLES - 1);
  localparam logic [PWM_WIDTH-1:0] DutyTop  = PWM_WIDTH'(duty_max(PWM_WIDTH));

  state_e               state_q, state_d;
  logic                 target_q, target_d;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic [StepW-1:0]     step_q, step_d;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic                 accept;
  logic                 step_tick;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    hold_d    = hold_q;
    step_d    = step_q;
    duty_d    = duty_q;
    accept    = (hold_q == '0) && (bus.toglite_state != target_q);
    step_tick = (step_q == StepLast);

    if (hold_q != '0) hold_d = hold_q - HoldW'(1);

    // A newly accepted level wins over any step due this cycle.
    if (accept) begin
      target_d = bus.toglite_state;
      hold_d   = HoldLoad;
      step_d   = '0;
      state_d  = bus.toglite_state ? StRampUp : StRampDown;
    end else begin
      case (state_q)
        StRampUp: begin
          if (duty_q == DutyTop) begin
            state_d = StIdleOn;
          end else if (step_tick) begin
            step_d = '0;
            duty_d = duty_q + PWM_WIDTH'(1);
            if (duty_d == DutyTop) state_d = StIdleOn;
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
        StRampDown: begin
          if (duty_q == '0) begin
            state_d = StIdleOff;
          end else if (step_tick) begin
            step_d = '0;
            duty_d = duty_q - PWM_WIDTH'(1);
            if (duty_d == '0) state_d = StIdleOff;
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
        StIdleOn, StIdleOff: step_d = '0;
        default: state_d = StIdleOff;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q  <= StIdleOff;
      target_q <= 1'b0;
      hold_q   <= '0;
      step_q   <= '0;
      duty_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      hold_q   <= hold_d;
      step_q   <= step_d;
      duty_q   <= duty_d;
    end
  end

  light_fade_driver_pwm_generator #(
    .PWM_WIDTH (PWM_WIDTH)
  ) u_pwm (
    .clock     (clock),
    .nreset    (nreset),
    .duty      (duty_q),
    .light_pwm (bus.light_pwm)
  );

  assign bus.duty_level = duty_q;
  assign bus.fading     = (state_q == StRampUp) || (state_q == StRampDown);
  assign bus.lockout    = (hold_q != '0);

endmodule

// File: tb/tb_light_fade_driver.sv
// Bench for light_fade_driver: fade outputs follow a time-since-acceptance formula model.
module tb_light_fade_driver;

  localparam int PW   = 4;
  localparam int DMAX = 15;
  localparam int FS   = 4;
  localparam int HOLD = 20;

  logic clock;
  logic nreset;
  logic [PW-1:0] pwm_duty;
  logic pwm_out;

  light_fade_driver_if #(.PWM_WIDTH(PW)) bus ();

  light_fade_driver #(
    .PWM_WIDTH        (PW),
    .FADE_STEP_CYCLES (FS),
    .MIN_HOLD_CYCLES  (HOLD)
  ) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  light_fade_driver_pwm_generator #(
    .PWM_WIDTH (PW)
  ) pwm_dut (
    .clock     (clock),
    .nreset    (nreset),
    .duty      (pwm_duty),
    .light_pwm (pwm_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total;
  int bad;

  // Model: duty is a clamped linear function of cycles since the last accepted change.
  int cyc;
  int t_acc;
  int d0;
  int dir;
  bit m_target;
  int m_duty;
  bit m_fading;
  bit m_lockout;
  int m_shadow;
  bit m_pwm;

  task automatic model_reset();
    cyc = 0; t_acc = -1; d0 = 0; dir = 0; m_target = 1'b0;
    m_duty = 0; m_fading = 1'b0; m_lockout = 1'b0; m_shadow = 0; m_pwm = 1'b0;
  endtask

  task automatic model_edge(input bit in);
    int k;
    int dd;
    int pre;
    pre = m_duty;
    if (!m_lockout && in != m_target) begin
      t_acc = cyc; d0 = m_duty; dir = in ? 1 : -1; m_target = in;
    end
    if (t_acc >= 0) begin
      k  = cyc - t_acc;
      dd = d0 + dir * (k / FS);
      if (dd < 0) dd = 0;
      if (dd > DMAX) dd = DMAX;
      m_duty    = dd;
      m_fading  = (dir > 0) ? (dd < DMAX) : (dd > 0);
      m_lockout = (k < HOLD);
    end
    if (cyc % DMAX == 0) m_shadow = pre;
    m_pwm = (cyc % DMAX) < m_shadow;
    cyc++;
  endtask

  task automatic tick(input bit in);
    bus.toglite_state = in;
    model_edge(in);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    nreset = 1'b0;
    bus.toglite_state = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    nreset = 1'b1;
    model_reset();
  endtask

  function automatic logic [PW+2:0] exp_vec();
    return {PW'(m_duty), m_fading, m_lockout, m_pwm};
  endfunction

  function automatic logic [PW+2:0] obs_vec();
    return {bus.duty_level, bus.fading, bus.lockout, bus.light_pwm};
  endfunction

  task automatic test_reset();
    do_reset(5);
    total++;
    if (obs_vec() !== 7'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0000000", obs_vec());
    end
    for (int i = 0; i < 100; i++) begin
      tick(1'b0);
      total++;
      if (bus.light_pwm !== 1'b0 || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL idle_off cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_ramp_up();
    int highs;
    do_reset(2);
    for (int k = 0; k <= 60; k++) begin
      tick(1'b1);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL ramp_up k=%0d: got %b want %b", k, obs_vec(), exp_vec());
      end
      if (k == 0) begin
        total++;
        if (bus.lockout !== 1'b1 || bus.fading !== 1'b1) begin
          bad++; $display("FAIL accept_flags: lockout=%b fading=%b want 1 1", bus.lockout, bus.fading);
        end
      end
      if (k == 19 || k == 20) begin
        total++;
        if (bus.lockout !== (k == 19)) begin
          bad++; $display("FAIL lockout_len k=%0d: got %b want %b", k, bus.lockout, k == 19);
        end
      end
      if (k == 4) begin
        total++;
        if (bus.duty_level !== 4'd1) begin
          bad++; $display("FAIL first_step: got %0d want 1", bus.duty_level);
        end
      end
      if (k == 59 || k == 60) begin
        total++;
        if (bus.duty_level !== ((k == 60) ? 4'd15 : 4'd14) || bus.fading !== (k == 59)) begin
          bad++; $display("FAIL ramp_end k=%0d: duty=%0d fading=%b", k, bus.duty_level, bus.fading);
        end
      end
    end
    highs = 0;
    for (int i = 0; i < 45; i++) begin
      tick(1'b1);
      if (i >= 15 && bus.light_pwm === 1'b1) highs++;
    end
    total++;
    if (highs !== 30) begin
      bad++; $display("FAIL full_on_pwm: got %0d high cycles want 30", highs);
    end
  endtask

  task automatic test_steady_duty();
    int sh;
    int e;
    int hi_a;
    int hi_b;
    bit exp_p;
    pwm_duty = 4'd8;
    do_reset(2);
    sh = 0; hi_a = 0; hi_b = 0;
    for (int i = 0; i < 75; i++) begin
      e = i;
      if (e == 52) pwm_duty = 4'd3;
      if (e % DMAX == 0) sh = int'(pwm_duty);
      exp_p = (e % DMAX) < sh;
      tick(1'b0);
      total++;
      if (pwm_out !== exp_p) begin
        bad++; $display("FAIL steady_pwm e=%0d: got %b want %b", e, pwm_out, exp_p);
      end
      if (e >= 45 && e < 60 && pwm_out === 1'b1) hi_a++;
      if (e >= 60 && pwm_out === 1'b1) hi_b++;
    end
    total++;
    if (hi_a !== 8 || hi_b !== 3) begin
      bad++; $display("FAIL duty_period_count: got %0d/%0d want 8/3", hi_a, hi_b);
    end
  endtask

  task automatic test_lockout_toggle();
    bit in;
    bit dropped;
    do_reset(2);
    dropped = 1'b0;
    for (int k = 0; k <= 70; k++) begin
      in = !(k == 2 || k == 3);
      tick(in);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL lock_toggle k=%0d: got %b want %b", k, obs_vec(), exp_vec());
      end
      if (k < 60 && bus.fading !== 1'b1) dropped = 1'b1;
    end
    total++;
    if (dropped || bus.duty_level !== 4'd15) begin
      bad++; $display("FAIL uninterrupted: dropped=%b duty=%0d want 0 15", dropped, bus.duty_level);
    end
  endtask

  task automatic test_reversal();
    do_reset(2);
    for (int k = 0; k <= 24; k++) tick(1'b1);
    total++;
    if (bus.duty_level !== 4'd6 || bus.lockout !== 1'b0) begin
      bad++; $display("FAIL pre_reverse: duty=%0d lockout=%b want 6 0", bus.duty_level, bus.lockout);
    end
    for (int j = 0; j <= 24; j++) begin
      tick(1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reverse j=%0d: got %b want %b", j, obs_vec(), exp_vec());
      end
      if (j == 0 || j == 23 || j == 24) begin
        total++;
        if (bus.duty_level !== ((j == 0) ? 4'd6 : (j == 23) ? 4'd1 : 4'd0) ||
            bus.fading !== (j != 24)) begin
          bad++; $display("FAIL reverse_pts j=%0d: duty=%0d fading=%b", j, bus.duty_level, bus.fading);
        end
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset(2);
    for (int k = 0; k <= 36; k++) tick(1'b1);
    total++;
    if (bus.duty_level !== 4'd9) begin
      bad++; $display("FAIL mid_duty: got %0d want 9", bus.duty_level);
    end
    do_reset(1);
    total++;
    if (obs_vec() !== 7'd0) begin
      bad++; $display("FAIL mid_reset: got %b want 0000000", obs_vec());
    end
    for (int k = 0; k <= 4; k++) begin
      tick(1'b1);
      total++;
      if (obs_vec() !== exp_vec() || (k == 0 && (bus.lockout !== 1'b1 || bus.fading !== 1'b1))
          || (k == 4 && bus.duty_level !== 4'd1)) begin
        bad++; $display("FAIL reaccept k=%0d: got %b want %b", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit in;
    do_reset(3);
    in = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 11) == 0) in = ~in;
      tick(in);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random i=%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    nreset = 1'b0;
    pwm_duty = '0;
    bus.toglite_state = 1'b0;
    model_reset();
    test_reset();
    test_ramp_up();
    test_steady_duty();
    test_lockout_toggle();
    test_reversal();
    test_reset_mid_ramp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
